// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one shift/trial-subtract step per clock.
// Divide-by-zero returns all-ones quotient and the dividend as remainder.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;

  // Shifted partial remainder and trial subtraction R' - D as R' + ~D + 1
  assign r_shift = {r_q, q_q[WIDTH-1]};
  assign trial   = r_shift + ~{1'b0, dv_q} + (WIDTH+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dv_d = divisor;
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        // Non-negative trial keeps the difference and shifts in a quotient 1
        if (!trial[WIDTH]) begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_shift[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          quot_d  = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: a timeline model using plain / and % is
// compared every cycle, plus directed literal cases and an exhaustive sweep.
module tb_seq_restoring_divider;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op is busy for WIDTH cycles, then shows the
  // / and % results with a one-cycle done; divide-by-zero goes straight to done.
  logic             m_idle = 1'b1;
  int unsigned      m_left = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] p_q = '0, p_r = '0;
  logic [WIDTH-1:0] e_q = '0, e_r = '0;
  logic             e_dbz = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_idle <= 1'b1;
      m_left <= 0;
      m_done <= 1'b0;
      e_q    <= '0;
      e_r    <= '0;
      e_dbz  <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        e_q    <= p_q;
        e_r    <= p_r;
        e_dbz  <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (m_idle && start) begin
      m_idle <= 1'b0;
      if (divisor == 0) begin
        e_q    <= '1;
        e_r    <= dividend;
        e_dbz  <= 1'b1;
        m_done <= 1'b1;
      end else begin
        p_q    <= WIDTH'(dividend / divisor);
        p_r    <= WIDTH'(dividend % divisor);
        m_left <= WIDTH;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("quotient", 32'(quotient), 32'(e_q));
    chk("remainder", 32'(remainder), 32'(e_r));
    chk("div_by_zero", 32'(div_by_zero), 32'(e_dbz));
  end

  task automatic wait_idle();
    int n = 0;
    while (!m_idle && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_idle_timeout", 32'(m_idle), 32'd1);
  endtask

  // Directed op with literal expectations; optionally pulses start with 2/1 mid-CALC
  task automatic run_dir(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int eq, input int er, input int edbz, input int elat,
                         input int ebusy, input bit poke);
    int nb = 0;
    int lat = 0;
    bit got = 1'b0;
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
    for (int i = 1; i <= int'(WIDTH) + 3 && !got; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        got = 1'b1;
        lat = i;
      end
      if (poke && i == 2) begin
        start = 1'b1; dividend = 4'd2; divisor = 4'd1;
      end
      if (poke && i == 3) start = 1'b0;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'(elat));
    chk({name, "_busy_cycles"}, 32'(nb), 32'(ebusy));
    chk({name, "_quotient"}, 32'(quotient), 32'(eq));
    chk({name, "_remainder"}, 32'(remainder), 32'(er));
    chk({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_dir("d13_3", 4'd13, 4'd3, 4, 1, 0, WIDTH + 1, WIDTH, 1'b0);
    run_dir("d15_1", 4'd15, 4'd1, 15, 0, 0, WIDTH + 1, WIDTH, 1'b0);
    run_dir("d5_9", 4'd5, 4'd9, 0, 5, 0, WIDTH + 1, WIDTH, 1'b0);
    run_dir("d7_0", 4'd7, 4'd0, 15, 7, 1, 1, 0, 1'b0);
    run_dir("poke13_3", 4'd13, 4'd3, 4, 1, 0, WIDTH + 1, WIDTH, 1'b1);

    // Abort at CALC step 2: outputs clear immediately
    wait_idle();
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_dir("d9_2", 4'd9, 4'd2, 4, 1, 0, WIDTH + 1, WIDTH, 1'b0);

    // Exhaustive sweep, each start issued as soon as the divider is idle
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        wait_idle();
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
      end
    end

    // Random ops with random gaps and stray start pulses while busy
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 8)) begin
        @(posedge clk);
        #1;
        start    = 1'($urandom);
        dividend = WIDTH'($urandom);
        divisor  = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      end
    end
    start = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
